macc_out_packer: RTL and testbench

MACC_OUT_PACKER -- requirements
Module: macc_out_packer

---
 rtl/macc_pack_pkg.sv | 26 ++
 rtl/macc_pack_fifo.sv | 54 +++++
 rtl/macc_out_packer.sv | 160 ++++++++++++++++
 tb/tb_macc_out_packer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/macc_pack_pkg.sv
// Shared constants and sizing helpers for the macc output packer.
package macc_pack_pkg;

    localparam int unsigned FIFO_MIN_DEPTH = 2;

    function automatic int unsigned lane_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned fifo_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic longint round_bias(input int unsigned frac);
        return longint'(1) <<< (frac - 1);
    endfunction

    function automatic longint sat_max(input int unsigned w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int unsigned w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/macc_pack_fifo.sv
// Synchronous power-of-two FIFO with occupancy output; storage cleared by reset.
module macc_pack_fifo
    import macc_pack_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PW = fifo_ptr_w(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i)
            count_d = count_q + CW'(1);
        else if (!push_i && pop_i)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++)
                mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_i)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/macc_out_packer.sv
// Rounds/saturates accumulator samples, packs PACK_NUM lanes per word, buffers words in a FIFO.
// Optional build macro: MACC_PACK_RELU_EN clamps negative lane values to zero.
`ifndef PRECISION_ACC
`define PRECISION_ACC 32
`endif
`ifndef PRECISION_OP
`define PRECISION_OP 16
`endif
`ifndef PRECISION_FRAC
`define PRECISION_FRAC 8
`endif

module macc_out_packer
    import macc_pack_pkg::*;
#(
    parameter int unsigned ACC_WIDTH  = `PRECISION_ACC,
    parameter int unsigned OUT_WIDTH  = `PRECISION_OP,
    parameter int unsigned FRAC_BITS  = `PRECISION_FRAC,
    parameter int unsigned PACK_NUM   = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [ACC_WIDTH-1:0]   in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_WIDTH*PACK_NUM-1:0] out_data,
    output logic                          out_last,
    output logic                          sat_flag,
    input  logic                          clear_flag
);

    localparam int unsigned RW = ACC_WIDTH + 1;
    localparam int unsigned WW = OUT_WIDTH * PACK_NUM;
    localparam int unsigned LW = lane_idx_w(PACK_NUM);
    localparam int unsigned CW = fifo_ptr_w(FIFO_DEPTH) + 1;
    localparam logic signed [RW-1:0] BIAS    = RW'(round_bias(FRAC_BITS));
    localparam logic signed [RW-1:0] SAT_MAX = RW'(sat_max(OUT_WIDTH));
    localparam logic signed [RW-1:0] SAT_MIN = RW'(sat_min(OUT_WIDTH));
    localparam logic [LW-1:0]        LAST_LANE = LW'(PACK_NUM - 1);

    logic                 accept_c;
    logic signed [RW-1:0] sum_c, rnd_c;
    logic [OUT_WIDTH-1:0] lane_val_c;
    logic                 ovf_c;

    logic                 s1_valid_q, s1_last_q;
    logic [OUT_WIDTH-1:0] s1_data_q;
    logic [LW-1:0]        cnt_q, cnt_d;
    logic [WW-1:0]        lanes_q, lanes_d, word_c;
    logic                 complete_c;
    logic                 sat_q, sat_d;
    logic                 ready_en_q;

    logic                 fifo_pop_c, fifo_empty;
    logic [WW:0]          fifo_rd_data;
    logic [CW-1:0]        fifo_count;

    assign accept_c = in_valid && in_ready;

    // Stage-1 datapath: round half toward +inf, then saturate to the lane range.
    always_comb begin
        sum_c      = {in_data[ACC_WIDTH-1], in_data} + BIAS;
        rnd_c      = sum_c >>> FRAC_BITS;
        lane_val_c = rnd_c[OUT_WIDTH-1:0];
        ovf_c      = 1'b0;
        if (rnd_c > SAT_MAX) begin
            lane_val_c = SAT_MAX[OUT_WIDTH-1:0];
            ovf_c      = 1'b1;
        end else if (rnd_c < SAT_MIN) begin
            lane_val_c = SAT_MIN[OUT_WIDTH-1:0];
            ovf_c      = 1'b1;
        end
`ifdef MACC_PACK_RELU_EN
        if (rnd_c < 0) begin
            lane_val_c = '0;
            ovf_c      = 1'b0;
        end
`endif
    end

    // Packer: merge the stage-1 result into its lane and detect word completion.
    always_comb begin
        word_c     = lanes_q;
        lanes_d    = lanes_q;
        cnt_d      = cnt_q;
        complete_c = 1'b0;
        for (int i = 0; i < int'(PACK_NUM); i++)
            if (LW'(i) == cnt_q)
                word_c[i*OUT_WIDTH +: OUT_WIDTH] = s1_data_q;
        if (s1_valid_q) begin
            complete_c = (cnt_q == LAST_LANE) || s1_last_q;
            if (complete_c) begin
                lanes_d = '0;
                cnt_d   = '0;
            end else begin
                lanes_d = word_c;
                cnt_d   = cnt_q + LW'(1);
            end
        end
    end

    // Sticky saturation flag; a new saturation wins over a same-cycle clear.
    always_comb begin
        sat_d = sat_q;
        if (clear_flag)
            sat_d = 1'b0;
        if (accept_c && ovf_c)
            sat_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_data_q  <= '0;
            cnt_q      <= '0;
            lanes_q    <= '0;
            sat_q      <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            s1_valid_q <= accept_c;
            if (accept_c) begin
                s1_last_q <= in_last;
                s1_data_q <= lane_val_c;
            end
            cnt_q      <= cnt_d;
            lanes_q    <= lanes_d;
            sat_q      <= sat_d;
            ready_en_q <= 1'b1;
        end
    end

    assign fifo_pop_c = out_ready && !fifo_empty;

    macc_pack_fifo #(
        .WIDTH (WW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (complete_c),
        .push_data_i ({s1_last_q, word_c}),
        .pop_i       (fifo_pop_c),
        .pop_data_o  (fifo_rd_data),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Headroom of one slot covers the single word that can still be in flight.
    assign in_ready  = ready_en_q && (fifo_count <= CW'(FIFO_DEPTH - 2));
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_rd_data[WW-1:0];
    assign out_last  = fifo_rd_data[WW];
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_macc_out_packer.sv
// Directed self-checking bench for macc_out_packer (32-bit acc, 16-bit lanes, 4 lanes, depth-4 FIFO).
module tb_macc_out_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        out_last;
    logic        sat_flag;
    logic        clear_flag = 1'b0;

    int tests = 0;
    int fails = 0;

    macc_out_packer #(
        .ACC_WIDTH  (32),
        .OUT_WIDTH  (16),
        .FRAC_BITS  (8),
        .PACK_NUM   (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .sat_flag   (sat_flag),
        .clear_flag (clear_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one sample from a falling edge; returns once it will be taken at the next rising edge.
    task automatic send(input logic [31:0] d, input logic l);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = d;
            in_last  = l;
            if (in_ready) return;
        end
        check("send_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid   = 1'b0;
        in_last    = 1'b0;
        clear_flag = 1'b0;
    endtask

    task automatic pop_word(input string tag, input logic [63:0] exp_d, input logic exp_l);
        for (int c = 0; c < 30 && !out_valid; c++)
            @(negedge clk);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"}, out_data, exp_d);
        check({tag, "_last"}, 64'(out_last), 64'(exp_l));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [63:0] exp_words [4];
    logic [63:0] held;
    logic [63:0] neg_lane;
    logic        neg_sat;
    int          sent, got;

    initial begin
`ifdef MACC_PACK_RELU_EN
        neg_lane = 64'h0;
        neg_sat  = 1'b0;
`else
        neg_lane = 64'h8000;
        neg_sat  = 1'b1;
`endif
        exp_words[0] = 64'h0004_0003_0002_0001;
        exp_words[1] = 64'h0008_0007_0006_0005;
        exp_words[2] = 64'h000C_000B_000A_0009;
        exp_words[3] = 64'h0010_000F_000E_000D;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_sat_flag", 64'(sat_flag), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        #1 check("rel_in_ready_low", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("rel_in_ready_high", 64'(in_ready), 64'd1);

        // Rounding of a plain word
        send(32'h0000_0180, 1'b0);
        send(32'h0000_0100, 1'b0);
        send(32'h0000_0200, 1'b0);
        send(32'h0000_0300, 1'b0);
        idle();
        pop_word("basic", 64'h0003_0002_0001_0002, 1'b0);
        check("basic_no_sat", 64'(sat_flag), 64'd0);

        // Saturation, negative rounding and the sticky flag
        send(32'h0100_0000, 1'b0);
        idle();
        check("sat_set", 64'(sat_flag), 64'd1);
        send(32'hFF00_0000, 1'b0);
        send(32'h0000_0080, 1'b0);
        send(32'hFFFF_FE80, 1'b0);
        idle();
`ifdef MACC_PACK_RELU_EN
        pop_word("sat", 64'h0000_0001_0000_7FFF, 1'b0);
`else
        pop_word("sat", 64'hFFFF_0001_8000_7FFF, 1'b0);
`endif
        @(negedge clk);
        clear_flag = 1'b1;
        @(negedge clk);
        clear_flag = 1'b0;
        check("sat_clear", 64'(sat_flag), 64'd0);

        // Negative-only saturation (ReLU suppresses it)
        send(32'hFF00_0000, 1'b1);
        idle();
        check("neg_sat_flag", 64'(sat_flag), 64'(neg_sat));
        pop_word("neg", neg_lane, 1'b1);
        clear_flag = 1'b1;
        @(negedge clk);
        clear_flag = 1'b0;
        check("neg_clear", 64'(sat_flag), 64'd0);

        // Set wins over a simultaneous clear
        send(32'h0100_0000, 1'b0);
        clear_flag = 1'b1;
        idle();
        check("set_over_clear", 64'(sat_flag), 64'd1);
        send(32'h0000_0000, 1'b1);
        idle();
        pop_word("prio", 64'h0000_0000_0000_7FFF, 1'b1);
        clear_flag = 1'b1;
        @(negedge clk);
        clear_flag = 1'b0;

        // Early flush, then the next word restarts at lane 0
        send(32'h0000_0500, 1'b0);
        send(32'h0000_0600, 1'b1);
        send(32'h0000_0100, 1'b0);
        send(32'h0000_0200, 1'b0);
        send(32'h0000_0300, 1'b0);
        send(32'h0000_0400, 1'b0);
        idle();
        pop_word("flush", 64'h0000_0000_0006_0005, 1'b1);
        pop_word("restart", 64'h0004_0003_0002_0001, 1'b0);

        // Back-pressure: 13 samples stream in, then in_ready drops at occupancy 3
        for (int i = 0; i < 13; i++)
            send(32'((i + 1) << 8), 1'b0);
        @(negedge clk);
        in_data = 32'(14 << 8);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_count3_valid", 64'(dut.u_fifo.count_o), 64'd3);
        held = out_data;
        repeat (3) @(negedge clk);
        check("bp_still_blocked", 64'(in_ready), 64'd0);
        check("bp_data_stable", out_data, held);
        check("bp_head_word", out_data, exp_words[0]);

        // Drain while the last three samples go in
        sent = 13;
        got  = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 60 && !(got == 4 && sent == 16); c++) begin
            if (out_valid) begin
                if (got < 4)
                    check("drain_word", out_data, exp_words[got]);
                got++;
            end
            if (sent < 16) begin
                in_valid = 1'b1;
                in_data  = 32'((sent + 1) << 8);
                if (in_ready) sent++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        out_ready = 1'b0;
        check("drain_count", 64'(got), 64'd4);
        check("drain_empty", 64'(out_valid), 64'd0);

        // Reset during a partial word with a full word still queued
        send(32'h0000_0900, 1'b0);
        send(32'h0000_0900, 1'b0);
        send(32'h0000_0900, 1'b0);
        send(32'h0000_0900, 1'b0);
        send(32'h0000_0700, 1'b0);
        send(32'h0000_0800, 1'b0);
        idle();
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_data", out_data, 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(32'h0000_0100, 1'b0);
        send(32'h0000_0200, 1'b0);
        send(32'h0000_0300, 1'b0);
        send(32'h0000_0400, 1'b0);
        idle();
        pop_word("post_rst", 64'h0004_0003_0002_0001, 1'b0);
        repeat (4) @(negedge clk);
        check("post_rst_no_extra", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
